alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU bus of alu_arbiter.
// slave: the arbiter side; master: the requesters, the ALU and the response consumer.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [3:0]  req0_op;
    logic [3:0]  req1_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_cout;
    logic        alu_overflow;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic [2:0]  resp_zcv;
    logic        resp_err;
    logic [15:0] done_cnt0;
    logic [15:0] done_cnt1;

    modport slave (
        input  req0_valid, req1_valid, req0_src1, req0_src2, req1_src1, req1_src2,
        input  req0_op, req1_op, alu_result, alu_zero, alu_cout, alu_overflow, resp_ready,
        output req0_ready, req1_ready, alu_src1, alu_src2, alu_ctrl,
        output resp_valid, resp_id, resp_result, resp_zcv, resp_err, done_cnt0, done_cnt1
    );

    modport master (
        output req0_valid, req1_valid, req0_src1, req0_src2, req1_src1, req1_src2,
        output req0_op, req1_op, alu_result, alu_zero, alu_cout, alu_overflow, resp_ready,
        input  req0_ready, req1_ready, alu_src1, alu_src2, alu_ctrl,
        input  resp_valid, resp_id, resp_result, resp_zcv, resp_err, done_cnt0, done_cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared ALU, one operation in flight.
// Illegal opcodes bypass the ALU and answer immediately with resp_err set.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(ALU_LAT - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic [1:0]  r_lat_cnt;
    logic [31:0] r_alu_src1;
    logic [31:0] r_alu_src2;
    logic [3:0]  r_alu_ctrl;
    logic        r_resp_id;
    logic [31:0] r_resp_result;
    logic [2:0]  r_resp_zcv;
    logic        r_resp_err;
    logic [15:0] r_done_cnt0;
    logic [15:0] r_done_cnt1;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_op_legal;
    logic [3:0]  w_op;
    logic [31:0] w_src1;
    logic [31:0] w_src2;

    // r_last_grant resets to 1 so that the first contended grant goes to port 0.
    always_comb begin
        w_idle   = !rst && (r_state == IDLE);
        w_grant0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last_grant);
        w_grant1 = w_idle && bus.req1_valid && !w_grant0;
        w_accept = w_grant0 || w_grant1;
        w_op     = w_grant1 ? bus.req1_op   : bus.req0_op;
        w_src1   = w_grant1 ? bus.req1_src1 : bus.req0_src1;
        w_src2   = w_grant1 ? bus.req1_src2 : bus.req0_src2;
        case (w_op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: w_op_legal = 1'b1;
            default:                              w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_lat_cnt     <= '0;
            r_alu_src1    <= '0;
            r_alu_src2    <= '0;
            r_alu_ctrl    <= '0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_zcv    <= '0;
            r_resp_err    <= 1'b0;
            r_done_cnt0   <= '0;
            r_done_cnt1   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant1;
                        r_resp_id    <= w_grant1;
                        if (w_op_legal) begin
                            r_alu_src1 <= w_src1;
                            r_alu_src2 <= w_src2;
                            r_alu_ctrl <= w_op;
                            r_lat_cnt  <= '0;
                            r_state    <= EXEC;
                        end else begin
                            r_resp_result <= '0;
                            r_resp_zcv    <= '0;
                            r_resp_err    <= 1'b1;
                            r_state       <= RESP;
                        end
                    end
                end
                EXEC: begin
                    // r_lat_cnt holds (edges since launch - 1); capture on the ALU_LAT-th edge.
                    if (r_lat_cnt == LAT_LAST) begin
                        r_resp_result <= bus.alu_result;
                        r_resp_zcv    <= {bus.alu_zero, bus.alu_cout, bus.alu_overflow};
                        r_resp_err    <= 1'b0;
                        r_state       <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= IDLE;
                        if (r_resp_id) begin
                            if (r_done_cnt1 != 16'hFFFF) r_done_cnt1 <= r_done_cnt1 + 16'd1;
                        end else begin
                            if (r_done_cnt0 != 16'hFFFF) r_done_cnt0 <= r_done_cnt0 + 16'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.alu_src1    = r_alu_src1;
    assign bus.alu_src2    = r_alu_src2;
    assign bus.alu_ctrl    = r_alu_ctrl;
    assign bus.resp_valid  = (r_state == RESP);
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_zcv    = r_resp_zcv;
    assign bus.resp_err    = r_resp_err;
    assign bus.done_cnt0   = r_done_cnt0;
    assign bus.done_cnt1   = r_done_cnt1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each fed by a small combinational ALU stub.
module tb_alu_arbiter;
    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [2:0] alu_flip;
    int         n_vec;
    int         n_bad;

    alu_arbiter_if ia ();
    alu_arbiter_if ib ();

    alu_arbiter #(.ALU_LAT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    alu_arbiter #(.ALU_LAT(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {zero, cout, overflow, result}.
    function automatic logic [34:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        ov;
        s = '0; r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd6: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd7:  r = {31'b0, $signed(a) < $signed(b)};
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
        return {(r == 32'h0), co, ov, r};
    endfunction

    always_comb begin
        {ia.alu_zero, ia.alu_cout, ia.alu_overflow, ia.alu_result} =
            alu_model(ia.alu_ctrl, ia.alu_src1, ia.alu_src2) ^ {alu_flip, 32'h0};
        {ib.alu_zero, ib.alu_cout, ib.alu_overflow, ib.alu_result} =
            alu_model(ib.alu_ctrl, ib.alu_src1, ib.alu_src2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input bit port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [2:0] zcv);
        int w;
        ia.resp_ready = 1'b1;
        if (port) begin
            ia.req1_op = op; ia.req1_src1 = a; ia.req1_src2 = b; ia.req1_valid = 1'b1;
        end else begin
            ia.req0_op = op; ia.req0_src1 = a; ia.req0_src2 = b; ia.req0_valid = 1'b1;
        end
        #1;
        w = 0;
        while (!(port ? ia.req1_ready : ia.req0_ready) && w < 20) begin
            tick(); #1; w++;
        end
        chk("op_accept", 32'(port ? ia.req1_ready : ia.req0_ready), 32'd1);
        tick();
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;
        #1;
        w = 0;
        while (!ia.resp_valid && w < 20) begin
            tick(); #1; w++;
        end
        chk("op_resp", 32'(ia.resp_valid), 32'd1);
        res = ia.resp_result;
        zcv = ia.resp_zcv;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res;
        logic [2:0]  zcv;
        bit   [3:0]  order;
        int          ng;
        int          both;
        int          cyc;

        n_vec = 0; n_bad = 0; alu_flip = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        {ia.req0_valid, ia.req1_valid, ia.resp_ready} = '0;
        {ib.req0_valid, ib.req1_valid, ib.resp_ready} = '0;
        {ia.req0_src1, ia.req0_src2, ia.req1_src1, ia.req1_src2} = '0;
        {ib.req0_src1, ib.req0_src2, ib.req1_src1, ib.req1_src2} = '0;
        {ia.req0_op, ia.req1_op, ib.req0_op, ib.req1_op} = '0;
        @(negedge clk);
        tick();

        // reset state, with both requests raised while reset is held
        ia.req0_valid = 1'b1; ia.req1_valid = 1'b1; #1;
        chk("rst_rdy0",   32'(ia.req0_ready), 32'd0);
        chk("rst_rdy1",   32'(ia.req1_ready), 32'd0);
        chk("rst_vld",    32'(ia.resp_valid), 32'd0);
        chk("rst_src1",   ia.alu_src1, 32'd0);
        chk("rst_src2",   ia.alu_src2, 32'd0);
        chk("rst_ctrl",   32'(ia.alu_ctrl), 32'd0);
        chk("rst_id",     32'(ia.resp_id), 32'd0);
        chk("rst_result", ia.resp_result, 32'd0);
        chk("rst_zcv",    32'(ia.resp_zcv), 32'd0);
        chk("rst_err",    32'(ia.resp_err), 32'd0);
        chk("rst_done0",  32'(ia.done_cnt0), 32'd0);
        chk("rst_done1",  32'(ia.done_cnt1), 32'd0);
        ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
        rst_a = 1'b0;
        tick();

        // single ADD, ALU_LAT=1
        ia.req0_src1 = 32'h7FFFFFFF; ia.req0_src2 = 32'h00000001; ia.req0_op = 4'd2;
        ia.resp_ready = 1'b1; ia.req0_valid = 1'b1; #1;
        chk("t1_rdy0", 32'(ia.req0_ready), 32'd1);
        chk("t1_rdy1", 32'(ia.req1_ready), 32'd0);
        tick();
        ia.req0_valid = 1'b0; #1;
        chk("t1_exec_vld", 32'(ia.resp_valid), 32'd0);
        chk("t1_src1",     ia.alu_src1, 32'h7FFFFFFF);
        chk("t1_ctrl",     32'(ia.alu_ctrl), 32'd2);
        tick();
        chk("t1_vld",    32'(ia.resp_valid), 32'd1);
        chk("t1_result", ia.resp_result, 32'h80000000);
        chk("t1_zcv",    32'(ia.resp_zcv), 32'd1);
        chk("t1_id",     32'(ia.resp_id), 32'd0);
        tick();
        chk("t1_done0",  32'(ia.done_cnt0), 32'd1);
        chk("t1_idle",   32'(ia.resp_valid), 32'd0);

        // contention from a fresh reset
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        ia.req0_op = 4'd0; ia.req0_src1 = 32'hF0F0F0F0; ia.req0_src2 = 32'hFF00FF00;
        ia.req1_op = 4'd1; ia.req1_src1 = 32'h0000FFFF; ia.req1_src2 = 32'h00FF0000;
        ia.req0_valid = 1'b1; ia.req1_valid = 1'b1; ia.resp_ready = 1'b1;
        ng = 0; both = 0; cyc = 0; order = '0;
        while (ng < 4 && cyc < 60) begin
            #1;
            if (ia.req0_ready && ia.req1_ready) both++;
            if (ia.req0_ready || ia.req1_ready) begin
                order[ng] = ia.req1_ready;
                ng++;
            end
            if (ia.resp_valid)
                chk("t2_result", ia.resp_result, ia.resp_id ? 32'h00FFFFFF : 32'hF000F000);
            tick();
            cyc++;
        end
        ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
        tick(); tick(); tick();
        chk("t2_grants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_order%0d", i), 32'(order[i]), 32'(i % 2));
        chk("t2_both_rdy", 32'(both), 32'd0);
        chk("t2_done0", 32'(ia.done_cnt0), 32'd2);
        chk("t2_done1", 32'(ia.done_cnt1), 32'd2);

        // backpressure on SUB 5-5; req1 waits and then withdraws
        ia.resp_ready = 1'b0;
        ia.req0_op = 4'd6; ia.req0_src1 = 32'd5; ia.req0_src2 = 32'd5; ia.req0_valid = 1'b1; #1;
        chk("t3_rdy0", 32'(ia.req0_ready), 32'd1);
        tick();
        ia.req0_valid = 1'b0;
        ia.req1_op = 4'd0; ia.req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_vld",    32'(ia.resp_valid), 32'd1);
            chk("t3_result", ia.resp_result, 32'h0);
            chk("t3_zcv",    32'(ia.resp_zcv), 32'd6);
            chk("t3_rdy1",   32'(ia.req1_ready), 32'd0);
            tick();
        end
        ia.req1_valid = 1'b0;
        ia.resp_ready = 1'b1;
        tick();
        #1;
        chk("t3_done0", 32'(ia.done_cnt0), 32'd3);
        chk("t3_done1", 32'(ia.done_cnt1), 32'd2);
        chk("t3_vld_off", 32'(ia.resp_valid), 32'd0);

        // flags and result passed through untouched
        alu_flip = 3'b101;
        run_op(1'b0, 4'd1, 32'hFFFF0000, 32'h0000FFFF, res, zcv);
        alu_flip = 3'b000;
        chk("tf_result", res, 32'hFFFFFFFF);
        chk("tf_zcv",    32'(zcv), 32'd5);

        // illegal opcode from req1
        ia.req1_op = 4'd3; ia.req1_src1 = 32'hDEADBEEF; ia.req1_src2 = 32'h12345678;
        ia.req1_valid = 1'b1; #1;
        chk("t4_rdy1", 32'(ia.req1_ready), 32'd1);
        tick();
        ia.req1_valid = 1'b0; #1;
        chk("t4_vld",    32'(ia.resp_valid), 32'd1);
        chk("t4_err",    32'(ia.resp_err), 32'd1);
        chk("t4_result", ia.resp_result, 32'h0);
        chk("t4_zcv",    32'(ia.resp_zcv), 32'd0);
        chk("t4_id",     32'(ia.resp_id), 32'd1);
        chk("t4_src1",   ia.alu_src1, 32'hFFFF0000);
        chk("t4_src2",   ia.alu_src2, 32'h0000FFFF);
        chk("t4_ctrl",   32'(ia.alu_ctrl), 32'd1);
        tick();
        chk("t4_done1",  32'(ia.done_cnt1), 32'd3);
        chk("t4_done0",  32'(ia.done_cnt0), 32'd4);

        // saturation: preload one below the ceiling instead of 65535 real ops
        force dut_a.r_done_cnt0 = 16'hFFFE;
        tick();
        release dut_a.r_done_cnt0;
        #1;
        chk("t5_pre", 32'(ia.done_cnt0), 32'h0000FFFE);
        run_op(1'b0, 4'd2, 32'd1, 32'd1, res, zcv);
        chk("t5_result", res, 32'd2);
        chk("t5_sat1", 32'(ia.done_cnt0), 32'h0000FFFF);
        run_op(1'b0, 4'd12, 32'h0F0F0F0F, 32'h00FF00FF, res, zcv);
        chk("t5_nor", res, 32'hF000F000);
        chk("t5_sat2", 32'(ia.done_cnt0), 32'h0000FFFF);
        chk("t5_done1", 32'(ia.done_cnt1), 32'd3);

        // ALU_LAT=3: SLT capture timing
        rst_b = 1'b0;
        ib.resp_ready = 1'b1;
        ib.req0_op = 4'd7; ib.req0_src1 = 32'd1; ib.req0_src2 = 32'd2; ib.req0_valid = 1'b1; #1;
        chk("b_rdy0", 32'(ib.req0_ready), 32'd1);
        tick();
        ib.req0_valid = 1'b0; #1;
        chk("b_e0_vld", 32'(ib.resp_valid), 32'd0);
        chk("b_ctrl",   32'(ib.alu_ctrl), 32'd7);
        tick();
        chk("b_e1_vld", 32'(ib.resp_valid), 32'd0);
        tick();
        chk("b_e2_vld", 32'(ib.resp_valid), 32'd0);
        tick();
        chk("b_e3_vld", 32'(ib.resp_valid), 32'd1);
        chk("b_result", ib.resp_result, 32'd1);
        chk("b_zcv",    32'(ib.resp_zcv), 32'd0);
        tick();
        chk("b_done0",  32'(ib.done_cnt0), 32'd1);

        // reset in the middle of EXEC
        ib.req0_op = 4'd2; ib.req0_src1 = 32'd3; ib.req0_src2 = 32'd4; ib.req0_valid = 1'b1;
        tick();
        ib.req0_valid = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b_abort_vld", 32'(ib.resp_valid), 32'd0);
            tick();
        end
        chk("b_abort_done0", 32'(ib.done_cnt0), 32'd0);
        chk("b_abort_done1", 32'(ib.done_cnt1), 32'd0);
        chk("b_abort_src1",  ib.alu_src1, 32'd0);
        ib.req0_valid = 1'b1; ib.req1_valid = 1'b1; #1;
        chk("b_next_rdy0", 32'(ib.req0_ready), 32'd1);
        chk("b_next_rdy1", 32'(ib.req1_ready), 32'd0);
        ib.req0_valid = 1'b0; ib.req1_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
